// File: rtl/adc_7seg_scan_driver.sv
// Binary sample -> 4-digit BCD (sequential double-dabble) and a continuous
// 8-position 7-seg scan through two lock-step 74HC595-style shift chains.
module adc_7seg_scan_driver #(
  parameter int DATA_W   = 10,
  parameter int CLK_DIV  = 2700,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              seg_ser,
  output logic              seg_srclk,
  output logic              seg_rclk,
  output logic              seg_oe_n,
  output logic              com_ser,
  output logic              com_srclk,
  output logic              com_rclk,
  output logic              com_oe_n
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} conv_state_t;

  conv_state_t       state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [15:0]       bcd_reg;
  logic [15:0]       disp_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [3:0]        adj_dig [3];
  logic [15:0]       bcd_shifted;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 8'hFC;
      4'd1: seg_code = 8'h60;
      4'd2: seg_code = 8'hDA;
      4'd3: seg_code = 8'hF2;
      4'd4: seg_code = 8'h66;
      4'd5: seg_code = 8'hB6;
      4'd6: seg_code = 8'hBE;
      4'd7: seg_code = 8'hE0;
      4'd8: seg_code = 8'hFE;
      4'd9: seg_code = 8'hF6;
      default: seg_code = 8'h00;
    endcase
  endfunction

  // The thousands digit never reaches 5 before a shift for DATA_W <= 13,
  // so only the lower three digits need the add-3 correction.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign adj_dig[gi] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                      : bcd_reg[gi*4 +: 4];
  end
  assign bcd_shifted = {bcd_reg[14:12], adj_dig[2], adj_dig[1], adj_dig[0], shift_reg[DATA_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (sample_valid) state_next = S_CONV;
      S_CONV:   if (bit_cnt_reg == BIT_W'(DATA_W - 1)) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign sample_ready = (state_reg == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      bit_cnt_reg <= '0;
      disp_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (sample_valid) begin
          shift_reg   <= sample;
          bcd_reg     <= '0;
          bit_cnt_reg <= '0;
        end
        S_CONV: begin
          shift_reg   <= shift_reg << 1;
          bcd_reg     <= bcd_shifted;
          bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
        end
        S_COMMIT: disp_reg <= bcd_reg;
        default: ;
      endcase
    end
  end

  // Scan engine
  logic [CNT_W-1:0] tick_cnt_reg;
  logic             tick;
  logic [4:0]       phase_reg;
  logic [2:0]       pos_reg;
  logic [7:0]       seg_pat_reg, com_pat_reg;
  logic [7:0]       digit_pat [4];
  logic [7:0]       cur_seg, cur_com, seg_byte, com_byte;
  logic             seg_ser_reg, com_ser_reg, srclk_reg, rclk_reg, oe_n_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    if (BLANK_LZ && gi > 0) begin : g_blank
      assign digit_pat[gi] = (disp_reg[15:gi*4] == '0) ? 8'h00 : seg_code(disp_reg[gi*4 +: 4]);
    end else begin : g_show
      assign digit_pat[gi] = seg_code(disp_reg[gi*4 +: 4]);
    end
  end

  assign tick     = (tick_cnt_reg == CNT_W'(CLK_DIV - 1));
  assign cur_seg  = pos_reg[2] ? 8'h00 : digit_pat[pos_reg[1:0]];
  assign cur_com  = ~(8'd1 << pos_reg);
  // Tick 0 shifts straight from the buffer while the frame latch loads.
  assign seg_byte = (phase_reg == 5'd0) ? cur_seg : seg_pat_reg;
  assign com_byte = (phase_reg == 5'd0) ? cur_com : com_pat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_reg <= '0;
    else        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg   <= '0;
      pos_reg     <= '0;
      seg_pat_reg <= '0;
      com_pat_reg <= '0;
      seg_ser_reg <= 1'b0;
      com_ser_reg <= 1'b0;
      srclk_reg   <= 1'b0;
      rclk_reg    <= 1'b0;
      oe_n_reg    <= 1'b1;
    end else if (tick) begin
      oe_n_reg <= 1'b0;
      if (phase_reg == 5'd0) begin
        seg_pat_reg <= cur_seg;
        com_pat_reg <= cur_com;
      end
      if (phase_reg < 5'd16) begin
        if (!phase_reg[0]) begin
          srclk_reg   <= 1'b0;
          seg_ser_reg <= seg_byte[phase_reg[3:1]];
          com_ser_reg <= com_byte[phase_reg[3:1]];
        end else begin
          srclk_reg <= 1'b1;
        end
      end else if (phase_reg == 5'd16) begin
        rclk_reg  <= 1'b1;
        srclk_reg <= 1'b0;
      end else begin
        rclk_reg <= 1'b0;
      end
      if (phase_reg == 5'd17) begin
        phase_reg <= '0;
        pos_reg   <= pos_reg + 3'd1;
      end else begin
        phase_reg <= phase_reg + 5'd1;
      end
    end
  end

  assign seg_ser   = seg_ser_reg;
  assign com_ser   = com_ser_reg;
  assign seg_srclk = srclk_reg;
  assign com_srclk = srclk_reg;
  assign seg_rclk  = rclk_reg;
  assign com_rclk  = rclk_reg;
  assign seg_oe_n  = oe_n_reg;
  assign com_oe_n  = oe_n_reg;
endmodule

// File: tb/tb_adc_7seg_scan_driver.sv
// Bench for adc_7seg_scan_driver: cycle-level arithmetic reference model plus
// decoding of the serial streams into latched frames.
module tb_adc_7seg_scan_driver;
  localparam int DATA_W  = 10;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] sample = '0;
  logic sample_valid = 1'b0;

  logic sample_ready, seg_ser, seg_srclk, seg_rclk, seg_oe_n;
  logic com_ser, com_srclk, com_rclk, com_oe_n;
  logic nb_ready, nb_seg_ser, nb_seg_srclk, nb_seg_rclk, nb_seg_oe_n;
  logic nb_com_ser, nb_com_srclk, nb_com_rclk, nb_com_oe_n;

  adc_7seg_scan_driver #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .seg_ser(seg_ser), .seg_srclk(seg_srclk),
    .seg_rclk(seg_rclk), .seg_oe_n(seg_oe_n), .com_ser(com_ser),
    .com_srclk(com_srclk), .com_rclk(com_rclk), .com_oe_n(com_oe_n));

  adc_7seg_scan_driver #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(nb_ready), .seg_ser(nb_seg_ser), .seg_srclk(nb_seg_srclk),
    .seg_rclk(nb_seg_rclk), .seg_oe_n(nb_seg_oe_n), .com_ser(nb_com_ser),
    .com_srclk(nb_com_srclk), .com_rclk(nb_com_rclk), .com_oe_n(nb_com_oe_n));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int   m_edges, m_busy, m_pend, m_buf;
  logic e_seg, e_seg_nb, e_com, e_srclk, e_rclk, e_oe_n;
  logic [7:0] m_pat, m_pat_nb, m_com;

  // stream decoder state
  logic prev_srclk, prev_rclk;
  logic [7:0] sh_seg, sh_com, sh_nb;
  logic [7:0] q_seg[$], q_com[$], q_nb[$];

  logic [7:0] exp_lz [16];
  logic [7:0] exp_nb [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hFC; 1: return 8'h60; 2: return 8'hDA; 3: return 8'hF2; 4: return 8'h66;
      5: return 8'hB6; 6: return 8'hBE; 7: return 8'hE0; 8: return 8'hFE; default: return 8'hF6;
    endcase
  endfunction

  function automatic logic [7:0] exp_pat(input int p, input int v, input bit lz);
    int pw = 1;
    if (p >= 4) return 8'h00;
    for (int i = 0; i < p; i++) pw *= 10;
    if (lz && p > 0 && v < pw) return 8'h00;
    return seg_of((v / pw) % 10);
  endfunction

  task automatic model_reset();
    m_edges = 0; m_busy = 0; m_pend = 0; m_buf = 0;
    e_seg = 0; e_seg_nb = 0; e_com = 0; e_srclk = 0; e_rclk = 0; e_oe_n = 1;
    m_pat = 0; m_pat_nb = 0; m_com = 0;
  endtask

  task automatic dec_reset();
    prev_srclk = 0; prev_rclk = 0; sh_seg = 0; sh_com = 0; sh_nb = 0;
    q_seg.delete(); q_com.delete(); q_nb.delete();
  endtask

  task automatic model_edge();
    int n, t, p;
    if (m_edges % CLK_DIV == CLK_DIV - 1) begin
      n = m_edges / CLK_DIV;
      t = n % 18;
      p = (n / 18) % 8;
      e_oe_n = 0;
      if (t == 0) begin
        m_pat    = exp_pat(p, m_buf, 1'b1);
        m_pat_nb = exp_pat(p, m_buf, 1'b0);
        m_com    = ~(8'd1 << p);
      end
      if (t < 16) begin
        if (t % 2 == 0) begin
          e_srclk = 0; e_seg = m_pat[t/2]; e_seg_nb = m_pat_nb[t/2]; e_com = m_com[t/2];
        end else begin
          e_srclk = 1;
        end
      end else if (t == 16) begin
        e_rclk = 1; e_srclk = 0;
      end else begin
        e_rclk = 0;
      end
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_buf = m_pend;
    end else if (sample_valid) begin
      m_pend = int'(sample);
      m_busy = DATA_W + 1;
      $display("accept sample=%0d at edge %0d", sample, m_edges);
    end
    m_edges++;
  endtask

  task automatic decode();
    if (seg_srclk && !prev_srclk) begin
      sh_seg = {seg_ser, sh_seg[7:1]};
      sh_com = {com_ser, sh_com[7:1]};
      sh_nb  = {nb_seg_ser, sh_nb[7:1]};
    end
    if (seg_rclk && !prev_rclk) begin
      q_seg.push_back(sh_seg); q_com.push_back(sh_com); q_nb.push_back(sh_nb);
    end
    prev_srclk = seg_srclk;
    prev_rclk  = seg_rclk;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("ready", {31'b0, sample_ready}, {31'b0, m_busy == 0});
    check_eq("outs", {24'b0, seg_ser, seg_srclk, seg_rclk, seg_oe_n, com_ser, com_srclk, com_rclk, com_oe_n},
             {24'b0, e_seg, e_srclk, e_rclk, e_oe_n, e_com, e_srclk, e_rclk, e_oe_n});
    check_eq("nb_outs", {27'b0, nb_ready, nb_seg_ser, nb_seg_srclk, nb_seg_rclk, nb_com_oe_n},
             {27'b0, m_busy == 0, e_seg_nb, e_srclk, e_rclk, e_oe_n});
    decode();
  endtask

  task automatic run_until(input int k);
    while (m_edges < k) step();
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ready"}, {31'b0, sample_ready}, 32'd1);
    check_eq({tag, "_outs"}, {24'b0, seg_ser, seg_srclk, seg_rclk, seg_oe_n, com_ser, com_srclk, com_rclk, com_oe_n},
             32'h11);
    check_eq({tag, "_nb_oe"}, {31'b0, nb_seg_oe_n}, 32'd1);
  endtask

  initial begin
    exp_lz = '{8'hFC, 8'h00, 8'hFC, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hF2, 8'hDA, 8'hFC, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_nb = '{8'hFC, 8'hFC, 8'hFC, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hF2, 8'hDA, 8'hFC, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
    model_reset();
    dec_reset();
    repeat (2) @(negedge clk);
    check_reset_outs("por");
    rst_n = 1'b1;

    // 1023 committed at tick 8 of the p=1 frame; 5 arrives mid-conversion
    run_until(96);
    sample = DATA_W'(1023); sample_valid = 1'b1; step(); sample_valid = 1'b0;
    run_until(100);
    sample = DATA_W'(5); sample_valid = 1'b1; step(); sample_valid = 1'b0;
    run_until(1160);
    sample = DATA_W'(7); sample_valid = 1'b1; step(); sample_valid = 1'b0;
    run_until(4 * 18 * 8 * CLK_DIV);

    check_eq("frame_count", q_seg.size(), 32);
    if (q_seg.size() == 32) begin
      for (int f = 0; f < 16; f++) begin
        check_eq($sformatf("frame%0d_seg", f), {24'b0, q_seg[f]}, {24'b0, exp_lz[f]});
        check_eq($sformatf("frame%0d_seg_nb", f), {24'b0, q_nb[f]}, {24'b0, exp_nb[f]});
        check_eq($sformatf("frame%0d_com", f), {24'b0, q_com[f]}, {24'b0, ~(8'd1 << (f % 8))});
      end
      check_eq("seven_p0", {24'b0, q_seg[24]}, 32'hE0);
      for (int f = 25; f < 28; f++) begin
        check_eq($sformatf("seven_p%0d", f - 24), {24'b0, q_seg[f]}, 32'h00);
        check_eq($sformatf("seven_nb_p%0d", f - 24), {24'b0, q_nb[f]}, 32'hFC);
      end
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample = ($urandom_range(0, 7) == 0) ? DATA_W'(1023) : DATA_W'($urandom_range(0, 1023));
      step();
    end
    sample_valid = 1'b0;

    // asynchronous reset in the middle of a conversion
    sample = DATA_W'(999);
    sample_valid = 1'b1;
    for (int i = 0; i < 20 && m_busy == 0; i++) step();
    sample_valid = 1'b0;
    check_eq("mid_busy", {31'b0, m_busy != 0}, 32'd1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 check_reset_outs("async");
    model_reset();
    dec_reset();
    @(negedge clk);
    check_reset_outs("held");
    rst_n = 1'b1;
    run_until(18 * 8 * CLK_DIV + 8);
    check_eq("post_frames", q_seg.size(), 8);
    if (q_seg.size() >= 2) begin
      check_eq("post_p0", {24'b0, q_seg[0]}, 32'hFC);
      check_eq("post_p1", {24'b0, q_seg[1]}, 32'h00);
      check_eq("post_nb_p1", {24'b0, q_nb[1]}, 32'hFC);
      check_eq("post_com0", {24'b0, q_com[0]}, 32'hFE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
